roi_pool_core: RTL

- Parametrised successor of the camera pre-processing core.
- Takes a valid-qualified pixel stream with explicit start-of-frame, crops a run-time-programmable region of interest (ROI), and pools each BLK_W x BLK_H block into one 8-bit sample.
- Pooling is average (rounded) or max, with saturation against a clip level.
- Writes the pooled OUT_W x OUT_H image into the padded LeNet input memory and flags completion per frame.

---
 rtl/roi_pool_core_if.sv | 29 ++
 rtl/roi_pool_core.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/roi_pool_core_if.sv
// Pixel-stream input and LeNet memory write port of the ROI pooling core.
// The master drives pixels and configuration; the slave is the core.
interface roi_pool_core_if #(
  parameter int ADDR_W = 10
);
  logic              pix_valid;
  logic              pix_sof;
  logic [7:0]        din;
  logic              lenet_signal;
  logic              pool_mode;
  logic [9:0]        roi_x;
  logic [9:0]        roi_y;
  logic [ADDR_W-1:0] addr_mem2;
  logic [7:0]        lenet_dout;
  logic              lenet_we;
  logic              data_ready;
  logic              busy;
  logic              frame_err;

  modport master (
    output pix_valid, pix_sof, din, lenet_signal, pool_mode, roi_x, roi_y,
    input  addr_mem2, lenet_dout, lenet_we, data_ready, busy, frame_err
  );

  modport slave (
    input  pix_valid, pix_sof, din, lenet_signal, pool_mode, roi_x, roi_y,
    output addr_mem2, lenet_dout, lenet_we, data_ready, busy, frame_err
  );
endinterface

// File: rtl/roi_pool_core.sv
// Crops a run-time ROI from a valid-qualified pixel stream and pools each
// BLK_W x BLK_H block (rounded average or max, clipped) into the LeNet memory.
module roi_pool_core #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int BLK_W      = 8,
  parameter int BLK_H      = 8,
  parameter int OUT_W      = 28,
  parameter int OUT_H      = 28,
  parameter int ADDR_W     = 10,
  parameter int ADDR_BASE  = 66,
  parameter int ADDR_PITCH = 32,
  parameter int CLIP_LEVEL = 255
) (
  input  logic           clk25,
  input  logic           rst_n,
  roi_pool_core_if.slave pix_if
);
  localparam int BW_L  = $clog2(BLK_W);
  localparam int BH_L  = $clog2(BLK_H);
  localparam int ACC_W = 8 + BW_L + BH_L;
  localparam int CI_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int CW    = 12;
  localparam logic [CW-1:0]    ROI_W  = CW'(OUT_W * BLK_W);
  localparam logic [CW-1:0]    ROI_H  = CW'(OUT_H * BLK_H);
  localparam logic [CW-1:0]    IMG_WV = CW'(IMG_W);
  localparam logic [CW-1:0]    IMG_HV = CW'(IMG_H);
  localparam logic [ACC_W-1:0] HALF   = ACC_W'(BLK_W * BLK_H / 2);
  localparam logic [8:0]       CLIP_V = 9'(CLIP_LEVEL);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t            state_q, state_d;
  logic [9:0]        hcnt_q, vcnt_q, roi_x_q, roi_y_q;
  logic              mode_q;
  logic [ACC_W-1:0]  acc_q [OUT_W];
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        dout_q;
  logic              we_q, ready_q, busy_q, err_q;

  logic              sof_s, latch_s, range_ok_s, start_s, abort_s, proc_s;
  logic              in_roi_s, hit_s, sub_first_s, sub_last_s, blk_last_s, frame_last_s;
  logic [9:0]        cur_h_s, cur_v_s, eff_x_s, eff_y_s;
  logic              eff_mode_s;
  logic [CW-1:0]     dx_s, dy_s, row_s;
  logic [CI_W-1:0]   col_s;
  logic [ACC_W-1:0]  sum_s, acc_nxt_s;
  logic [7:0]        avg_s, max_s, res_s, clip_s;
  logic [ADDR_W-1:0] addr_s;

  // Pixel coordinates, effective config, block arithmetic and FSM next state
  always_comb begin
    sof_s      = pix_if.pix_valid && pix_if.pix_sof;
    cur_h_s    = sof_s ? 10'd0 : hcnt_q;
    cur_v_s    = sof_s ? 10'd0 : vcnt_q;
    latch_s    = sof_s && ((state_q == ARMED && pix_if.lenet_signal) || state_q == CAPTURE);
    abort_s    = sof_s && (state_q == CAPTURE);
    // The sof pixel is already processed under the configuration latched with it
    eff_x_s    = latch_s ? pix_if.roi_x : roi_x_q;
    eff_y_s    = latch_s ? pix_if.roi_y : roi_y_q;
    eff_mode_s = latch_s ? pix_if.pool_mode : mode_q;
    range_ok_s = (({2'b00, eff_x_s} + ROI_W) <= IMG_WV) && (({2'b00, eff_y_s} + ROI_H) <= IMG_HV);
    start_s    = latch_s && range_ok_s && pix_if.lenet_signal;
    proc_s     = pix_if.pix_valid && ((state_q == CAPTURE && !sof_s) || start_s);

    dx_s        = {2'b00, cur_h_s} - {2'b00, eff_x_s};
    dy_s        = {2'b00, cur_v_s} - {2'b00, eff_y_s};
    in_roi_s    = (cur_h_s >= eff_x_s) && (dx_s < ROI_W) && (cur_v_s >= eff_y_s) && (dy_s < ROI_H);
    hit_s       = proc_s && in_roi_s;
    sub_first_s = (dx_s[BW_L-1:0] == '0) && (dy_s[BH_L-1:0] == '0);
    sub_last_s  = (&dx_s[BW_L-1:0]) && (&dy_s[BH_L-1:0]);
    col_s       = dx_s[BW_L +: CI_W];
    row_s       = dy_s >> BH_L;

    sum_s  = acc_q[col_s] + ACC_W'(pix_if.din);
    avg_s  = 8'((sum_s + HALF) >> (BW_L + BH_L));
    max_s  = (acc_q[col_s][7:0] > pix_if.din) ? acc_q[col_s][7:0] : pix_if.din;
    res_s  = eff_mode_s ? max_s : avg_s;
    clip_s = ({1'b0, res_s} >= CLIP_V) ? 8'hFF : res_s;
    if (sub_first_s) begin
      acc_nxt_s = ACC_W'(pix_if.din);
    end else if (eff_mode_s) begin
      acc_nxt_s = ACC_W'(max_s);
    end else begin
      acc_nxt_s = sum_s;
    end
    addr_s = ADDR_W'(ADDR_BASE) + ADDR_W'(col_s) + ADDR_W'(ADDR_PITCH) * ADDR_W'(row_s);

    blk_last_s   = hit_s && sub_last_s;
    frame_last_s = blk_last_s && (col_s == CI_W'(OUT_W - 1)) && (row_s == CW'(OUT_H - 1));

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pix_if.lenet_signal) state_d = ARMED;
        else                     state_d = IDLE;
      end
      ARMED: begin
        if (!pix_if.lenet_signal) state_d = IDLE;
        else if (start_s)         state_d = CAPTURE;
        else                      state_d = ARMED;
      end
      CAPTURE: begin
        if (abort_s)           state_d = start_s ? CAPTURE : (pix_if.lenet_signal ? ARMED : IDLE);
        else if (frame_last_s) state_d = DONE;
        else                   state_d = CAPTURE;
      end
      DONE: begin
        if (pix_if.lenet_signal) state_d = ARMED;
        else                     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, position counters and configuration latched at sof
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hcnt_q  <= 10'd0;
      vcnt_q  <= 10'd0;
      roi_x_q <= 10'd0;
      roi_y_q <= 10'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pix_if.pix_valid) begin
        if (pix_if.pix_sof) begin
          hcnt_q <= 10'd1;
          vcnt_q <= 10'd0;
        end else if (hcnt_q == 10'(IMG_W - 1)) begin
          hcnt_q <= 10'd0;
          if (vcnt_q != 10'(IMG_H - 1)) vcnt_q <= vcnt_q + 10'd1;
        end else begin
          hcnt_q <= hcnt_q + 10'd1;
        end
      end
      if (latch_s) begin
        roi_x_q <= pix_if.roi_x;
        roi_y_q <= pix_if.roi_y;
        mode_q  <= pix_if.pool_mode;
      end
    end
  end

  // Per-column block accumulators; an abort discards partial blocks
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_W; i++) acc_q[i] <= '0;
    end else begin
      if (abort_s) begin
        for (int i = 0; i < OUT_W; i++) acc_q[i] <= '0;
      end
      if (hit_s) acc_q[col_s] <= acc_nxt_s;
    end
  end

  // Registered memory write port and status pulses
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      dout_q  <= 8'd0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= blk_last_s;
      ready_q <= (state_q == DONE);
      busy_q  <= (state_d == CAPTURE);
      err_q   <= latch_s && (abort_s || !range_ok_s);
      if (blk_last_s) begin
        addr_q <= addr_s;
        dout_q <= clip_s;
      end
    end
  end

  assign pix_if.addr_mem2  = addr_q;
  assign pix_if.lenet_dout = dout_q;
  assign pix_if.lenet_we   = we_q;
  assign pix_if.data_ready = ready_q;
  assign pix_if.busy       = busy_q;
  assign pix_if.frame_err  = err_q;
endmodule
